// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared widths and FSM state encoding for the memory arbiter
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int LINE_W_DEF = 256;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and main-memory bundle for the two-port arbiter
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
);

    // Requester side: port 0 is the I-cache, port 1 the D-cache
    logic [ADDR_W-1:0] rq0_addr;
    logic [ADDR_W-1:0] rq1_addr;
    logic [LINE_W-1:0] rq0_wr;
    logic [LINE_W-1:0] rq1_wr;
    logic              rq0_rw;
    logic              rq1_rw;
    logic              rq0_valid;
    logic              rq1_valid;
    logic              rq0_ready;
    logic              rq1_ready;
    logic [LINE_W-1:0] rq_rd;

    // Main-memory side
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wr;
    logic              mem_rw;
    logic              mem_valid_out;
    logic [LINE_W-1:0] mem_rd;
    logic              mem_ready;

    logic [1:0]        gnt;

    // Arbiter view
    modport slave (
        input  rq0_addr, rq1_addr, rq0_wr, rq1_wr, rq0_rw, rq1_rw,
        input  rq0_valid, rq1_valid, mem_rd, mem_ready,
        output rq0_ready, rq1_ready, rq_rd,
        output mem_addr, mem_wr, mem_rw, mem_valid_out, gnt
    );

    // Requesters plus memory model view
    modport master (
        output rq0_addr, rq1_addr, rq0_wr, rq1_wr, rq0_rw, rq1_rw,
        output rq0_valid, rq1_valid, mem_rd, mem_ready,
        input  rq0_ready, rq1_ready, rq_rd,
        input  mem_addr, mem_wr, mem_rw, mem_valid_out, gnt
    );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational two-way winner select with last-owner tie break
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       v0,
    input  logic       v1,
    input  logic       last,
    output logic [1:0] gnt
);

    // On a tie the port that did not own the bus last wins; a lone request always wins
    always_comb begin
        gnt = 2'b00;
        if (v0 && v1) begin
            gnt = last ? 2'b01 : 2'b10;
        end else if (v0) begin
            gnt = 2'b01;
        end else if (v1) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port cache-line arbiter to main memory; MEM_ARB_RR_EN enables round-robin ties
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
)(
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    arb_state_t        state;
    arb_state_t        state_nx;
    logic [1:0]        gnt_q;
    logic [1:0]        pick_gnt;
    logic              pick_last;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wr_q;
    logic              rw_q;
    logic [LINE_W-1:0] rd_q;

`ifdef MEM_ARB_RR_EN
    logic last_q;

    // Remember who was served last; reset favours port 0 on the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (state == IDLE && pick_gnt != 2'b00) begin
            last_q <= pick_gnt[1];
        end
    end

    assign pick_last = last_q;
`else
    // A fixed "port 0 was last" makes the D-cache win every tie
    assign pick_last = 1'b0;
`endif

    mem_arb_pick u_pick (
        .v0   (bus.rq0_valid),
        .v1   (bus.rq1_valid),
        .last (pick_last),
        .gnt  (pick_gnt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: a grant starts a transaction, mem_ready ends it, DONE lasts one cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_gnt != 2'b00) state_nx = BUSY;
            BUSY:    if (bus.mem_ready)     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state: request strobe while busy, owner's ready pulse in DONE
    always_comb begin
        bus.mem_valid_out = (state == BUSY);
        bus.rq0_ready     = (state == DONE) && gnt_q[0];
        bus.rq1_ready     = (state == DONE) && gnt_q[1];
    end

    // Datapath: latch the winner's request at grant, the memory line on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q  <= 2'b00;
            addr_q <= '0;
            wr_q   <= '0;
            rw_q   <= 1'b0;
            rd_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_gnt != 2'b00) begin
                        gnt_q  <= pick_gnt;
                        addr_q <= pick_gnt[1] ? bus.rq1_addr : bus.rq0_addr;
                        wr_q   <= pick_gnt[1] ? bus.rq1_wr   : bus.rq0_wr;
                        rw_q   <= pick_gnt[1] ? bus.rq1_rw   : bus.rq0_rw;
                    end
                end
                BUSY: begin
                    if (bus.mem_ready) begin
                        rd_q <= bus.mem_rd;
                    end
                end
                DONE: begin
                    gnt_q <= 2'b00;
                end
                default: begin
                    gnt_q <= 2'b00;
                end
            endcase
        end
    end

    assign bus.mem_addr = addr_q;
    assign bus.mem_wr   = wr_q;
    assign bus.mem_rw   = rw_q;
    assign bus.rq_rd    = rd_q;
    assign bus.gnt      = gnt_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, meaning line-address width.
REQ-002 SHALL have parameter LINE_W, default 256, meaning cache-line data width.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports rq0_addr / rq1_addr  input  ADDR_W  requester line address (port 0 = I-cache controller, port 1 = D-cache controller).
REQ-006 SHALL have ports rq0_wr / rq1_wr  input  LINE_W  requester write-back line.
REQ-007 SHALL have ports rq0_rw / rq1_rw  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports rq0_valid / rq1_valid  input  1  request pending; held until the matching ready.
REQ-009 SHALL have ports rq0_ready / rq1_ready  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rq_rd  output  LINE_W  read line, shared by both requesters, valid while either ready is high.
REQ-011 SHALL have ports mem_addr  output  ADDR_W, mem_wr  output  LINE_W, mem_rw  output  1, mem_valid_out  output  1  main-memory request.
REQ-012 SHALL have ports mem_rd  input  LINE_W, mem_ready  input  1  main-memory response.
REQ-013 SHALL have port gnt  output  2  one-hot owner of the current transaction, 2'b00 when idle.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 IDLE: if any rqN_valid is 1 at a clock edge, SHALL pick a winner, register its addr/wr/rw onto the mem_* outputs, set gnt, and enter BUSY; otherwise stay in IDLE.
REQ-016 BUSY: SHALL hold mem_valid_out=1 and the mem_* outputs stable; when mem_ready=1 at an edge, SHALL capture mem_rd into rq_rd, drop mem_valid_out, and enter DONE.
REQ-017 DONE: SHALL assert rqN_ready of the owner for exactly this one cycle, then clear gnt and return to IDLE; requests are not sampled in DONE.
REQ-018 Latency: request sampled at edge N -> mem_valid_out high from N; mem_ready sampled at edge M -> owner ready high for the cycle after M; minimum turnaround 3 cycles.
REQ-019 mem_ready while in IDLE or DONE SHALL be ignored.
REQ-020 A requester dropping valid during BUSY SHALL NOT abort the transaction; ready is still pulsed.
REQ-021 Write transactions SHALL still pulse ready; rq_rd then carries mem_rd as sampled.
REQ-022 The non-owner's request SHALL be held off (ready 0) until a later IDLE grant.

Reset
REQ-023 On rst_n=0, SHALL immediately enter IDLE and drive all outputs to 0 (mem_addr, mem_wr, mem_rw, mem_valid_out, rq_rd, rq0/rq1_ready, gnt).
REQ-024 Reset mid-transaction SHALL discard it; no ready pulse is issued afterwards.
REQ-025 On reset, the round-robin last-owner pointer SHALL be set to port 1, so port 0 wins the first tie.

Configuration
REQ-026 Macro MEM_ARB_RR_EN defined: simultaneous requests SHALL be granted to the port not served last; the pointer updates on each grant.
REQ-027 MEM_ARB_RR_EN undefined: port 1 (D-cache) SHALL always win ties; no pointer register exists.

Structure
REQ-028 Package mem_arb_pkg SHALL hold ADDR_W/LINE_W defaults and the state encoding IDLE=2'b00, BUSY=2'b01, DONE=2'b10.
REQ-029 The winner selection SHALL be a combinational sub-module mem_arb_pick (inputs: two valids and the last-owner pointer; output: one-hot grant).

Verification
REQ-030 Single read: rq0_valid=1, rq0_addr=28'h0000010, rq0_rw=0; mem_ready after 3 cycles with mem_rd=256'h0A0A0B0B...3FBABAF1 -> mem_addr=28'h0000010, rq0_ready pulses 1 cycle, rq_rd equals mem_rd.
REQ-031 Tie: rq0/rq1 valid in the same cycle after reset -> with MEM_ARB_RR_EN gnt=01 then 10; without it gnt=10 then 01.
REQ-032 Back-to-back ties with RR: both held valid for 4 transactions -> grants alternate 0,1,0,1.
REQ-033 Write: rq1_rw=1, rq1_wr=256'hABCD1234, mem_ready 1 cycle later -> mem_rw=1, mem_wr=256'hABCD1234, rq1_ready pulses, rq0 untouched.
REQ-034 Reset in BUSY: rst_n=0 while mem_valid_out=1 -> all outputs 0 asynchronously, no subsequent ready pulse.
REQ-035 Stray mem_ready=1 in IDLE with no request -> no ready pulse, rq_rd stays 0.
